relu_layer_ctrl: RTL

//  Sequences one ReLU layer of N_NEURONS neurons on board 2: y[i] = ReLU(z[i] + b[i]).

---
 rtl/relu_ctrl_pkg.sv | 14 +
 rtl/relu_layer_ctrl_relu.sv | 9 +
 rtl/relu_layer_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/relu_ctrl_pkg.sv
// relu_ctrl_pkg: shared state type, default sizes and bias adder for the ReLU layer controller
package relu_ctrl_pkg;
  localparam int DATA_W = 4;
  localparam int N_NEURONS = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} relu_ctrl_state_t;
  function automatic int sat_add(input int a, input int b, input bit sat, input int w);
    int s, hi, lo;
    s = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (sat) return s > hi ? hi : (s < lo ? lo : s);
    return (s << (32 - w)) >>> (32 - w);
  endfunction
endpackage

// File: rtl/relu_layer_ctrl_relu.sv
// relu: clamps a signed value to zero when negative
module relu #(
  parameter int DATA_W = 4
) (
  input  logic signed [DATA_W-1:0] x,
  output logic        [DATA_W-1:0] y
);
  assign y = x[DATA_W-1] ? '0 : x;
endmodule

// File: rtl/relu_layer_ctrl.sv
// relu_layer_ctrl: sequences one ReLU layer, y[i] = relu(z[i] + bias[i]) over a valid/ready stream
module relu_layer_ctrl
  import relu_ctrl_pkg::*;
#(
  parameter int DATA_W    = relu_ctrl_pkg::DATA_W,
  parameter int N_NEURONS = relu_ctrl_pkg::N_NEURONS,
  parameter int SAT       = 1,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     bias_we,
  input  logic [IDX_W-1:0]         bias_addr,
  input  logic signed [DATA_W-1:0] bias_wdata,
  input  logic                     z_valid,
  output logic                     z_ready,
  input  logic signed [DATA_W-1:0] z_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [DATA_W-1:0]        y_data,
  output logic [IDX_W-1:0]         y_idx,
  output logic                     busy,
  output logic                     done
);
  relu_ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [DATA_W-1:0] bias_q [N_NEURONS];
  logic signed [DATA_W-1:0] bias_d [N_NEURONS];
  logic y_valid_q, y_valid_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic [IDX_W-1:0] y_idx_q, y_idx_d;
  logic done_q, done_d;
  logic accept;
  logic signed [DATA_W-1:0] sum;
  logic [DATA_W-1:0] relu_y;
  assign sum = DATA_W'(sat_add(int'(z_data), int'(bias_q[idx_q]), SAT != 0, DATA_W));
  relu #(.DATA_W(DATA_W)) u_relu (.x(sum), .y(relu_y));
  // single output register: a new sample may enter whenever the held one leaves this cycle
  assign z_ready = (state_q == RUN) && (!y_valid_q || y_ready);
  assign accept  = z_valid && z_ready;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_idx   = y_idx_q;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bias_d    = bias_q;
    done_d    = 1'b0;
    y_valid_d = accept ? 1'b1 : (y_ready ? 1'b0 : y_valid_q);
    y_data_d  = accept ? relu_y : y_data_q;
    y_idx_d   = accept ? idx_q : y_idx_q;
    case (state_q)
      IDLE: begin
        if (bias_we && int'(bias_addr) < N_NEURONS) bias_d[bias_addr] = bias_wdata;
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          idx_d   = (idx_q == IDX_W'(N_NEURONS - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = (idx_q == IDX_W'(N_NEURONS - 1)) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (y_valid_q && y_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bias_q    <= '{default: '0};
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_idx_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bias_q    <= bias_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_idx_q   <= y_idx_d;
      done_q    <= done_d;
    end
  end
endmodule
